// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and helpers for the clk_gate_ctrl clock-gating controller.
// The optional gated-cycle statistics are enabled with CLK_GATE_CTRL_STATS_EN.
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2
    } gate_state_e;

    localparam int STATS_W = 32;

    // Saturating increment of the low w bits of v (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_chan.sv
// One clock-gating channel: OFF/WAKE/ON FSM with idle and wake counters
// driving a single integrated clock gate.
module clk_gate_ctrl_chan
    import clk_gate_ctrl_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int WAKE_CYCLES = 2,
    parameter bit RESET_ON    = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             test_en_i,
    input  logic             req_i,
    input  logic             busy_i,
    input  logic             force_on_i,
    input  logic [CNT_W-1:0] idle_thr_i,
    output logic             clk_o,
    output logic             clk_en_o,
    output logic             ready_o,
    output gate_state_e      state_o
);

    localparam int WC_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [WC_W-1:0] WAKE_LAST = WC_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

    gate_state_e      state_q, state_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic [WC_W-1:0]  wake_q, wake_d;
    logic             wake_req;
    logic             activity;

    // Handshake: req_i/force_on_i ask for the clock and must be held (or busy_i
    // asserted) to keep it; ready_o=1 means the gated clock is running and stable.
    // busy_i can only hold a running clock, never start a stopped one.
    assign wake_req = req_i | force_on_i;
    assign activity = req_i | busy_i | force_on_i;

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        wake_d  = wake_q;
        case (state_q)
            OFF: begin
                idle_d = '0;
                if (wake_req) begin
                    wake_d = '0;
                    if (WAKE_CYCLES == 0) begin
                        state_d = ON;
                    end else begin
                        state_d = WAKE;
                    end
                end
            end
            WAKE: begin
                if (wake_q == WAKE_LAST) begin
                    state_d = ON;
                end else begin
                    wake_d = wake_q + WC_W'(1);
                end
            end
            ON: begin
                // Activity wins over a threshold hit in the same cycle.
                if (activity) begin
                    idle_d = '0;
                end else if ((idle_thr_i != '0) && (idle_q >= idle_thr_i)) begin
                    state_d = OFF;
                    idle_d  = '0;
                end else begin
                    idle_d = CNT_W'(sat_inc(32'(idle_q), CNT_W));
                end
            end
            default: begin
                state_d = OFF;
                idle_d  = '0;
                wake_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RESET_ON ? ON : OFF;
            idle_q   <= '0;
            wake_q   <= '0;
            clk_en_o <= RESET_ON;
            ready_o  <= RESET_ON;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            wake_q   <= wake_d;
            clk_en_o <= (state_d != OFF);
            ready_o  <= (state_d == ON);
        end
    end

    assign state_o = state_q;

    pulp_clock_gating u_icg (
        .clk_i     (clk_i),
        .en_i      (clk_en_o),
        .test_en_i (test_en_i),
        .clk_o     (clk_o)
    );

endmodule

// File: rtl/pulp_clock_gating.sv
// Generic latch-based integrated clock gate: enable is captured while clk_i is
// low so the gated clock never glitches; test_en_i forces the gate transparent.
module pulp_clock_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic en_latch;

    always_latch begin
        if (!clk_i) begin
            en_latch = en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & en_latch;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Multi-channel automatic clock-gating controller (NUM_CH independent channels).
// Define CLK_GATE_CTRL_STATS_EN to add per-channel gated-cycle counters.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int WAKE_CYCLES = 2,
    parameter bit RESET_ON    = 1'b0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          test_en_i,
    input  logic [NUM_CH-1:0]             req_i,
    input  logic [NUM_CH-1:0]             busy_i,
    input  logic [NUM_CH-1:0]             force_on_i,
    input  logic [NUM_CH-1:0][CNT_W-1:0]  idle_thr_i,
`ifdef CLK_GATE_CTRL_STATS_EN
    input  logic                          stats_clr_i,
    output logic [NUM_CH-1:0][STATS_W-1:0] gated_cnt_o,
`endif
    output logic [NUM_CH-1:0]             clk_o,
    output logic [NUM_CH-1:0]             clk_en_o,
    output logic [NUM_CH-1:0]             ready_o,
    output logic                          all_gated_o,
    output gate_state_e [NUM_CH-1:0]      state_dbg_o
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_gate_ctrl_chan #(
            .CNT_W       (CNT_W),
            .WAKE_CYCLES (WAKE_CYCLES),
            .RESET_ON    (RESET_ON)
        ) u_chan (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .test_en_i  (test_en_i),
            .req_i      (req_i[i]),
            .busy_i     (busy_i[i]),
            .force_on_i (force_on_i[i]),
            .idle_thr_i (idle_thr_i[i]),
            .clk_o      (clk_o[i]),
            .clk_en_o   (clk_en_o[i]),
            .ready_o    (ready_o[i]),
            .state_o    (state_dbg_o[i])
        );
    end

    assign all_gated_o = ~|clk_en_o;

`ifdef CLK_GATE_CTRL_STATS_EN
    // Counts root-clock cycles spent with the channel gate closed; clear wins.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst_i || stats_clr_i) begin
                gated_cnt_o[i] <= '0;
            end else if (!clk_en_o[i]) begin
                gated_cnt_o[i] <= sat_inc(gated_cnt_o[i], STATS_W);
            end
        end
    end
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed self-checking bench for clk_gate_ctrl (RESET_ON=0 and RESET_ON=1 instances).
module tb_clk_gate_ctrl;
    import clk_gate_ctrl_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         rst;
    logic                         test_en;
    logic [NUM_CH-1:0]            req, busy, force_on;
    logic [NUM_CH-1:0][CNT_W-1:0] idle_thr;
    logic [NUM_CH-1:0]            clk_g, clk_en, ready;
    logic                         all_gated;
    gate_state_e [NUM_CH-1:0]     state_dbg;
    logic [NUM_CH-1:0]            clk_g_on, clk_en_on, ready_on;
    logic                         all_gated_on;
    gate_state_e [NUM_CH-1:0]     state_dbg_on;
`ifdef CLK_GATE_CTRL_STATS_EN
    logic                         stats_clr;
    logic [NUM_CH-1:0][31:0]      gated_cnt, gated_cnt_on;
`endif

    int checks = 0;
    int errors = 0;

    clk_gate_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WAKE_CYCLES(2), .RESET_ON(1'b0)) dut (
        .clk_i(clk), .rst_i(rst), .test_en_i(test_en), .req_i(req), .busy_i(busy),
        .force_on_i(force_on), .idle_thr_i(idle_thr),
`ifdef CLK_GATE_CTRL_STATS_EN
        .stats_clr_i(stats_clr), .gated_cnt_o(gated_cnt),
`endif
        .clk_o(clk_g), .clk_en_o(clk_en), .ready_o(ready), .all_gated_o(all_gated),
        .state_dbg_o(state_dbg)
    );

    clk_gate_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WAKE_CYCLES(2), .RESET_ON(1'b1)) dut_on (
        .clk_i(clk), .rst_i(rst), .test_en_i(test_en), .req_i(req), .busy_i(busy),
        .force_on_i(force_on), .idle_thr_i(idle_thr),
`ifdef CLK_GATE_CTRL_STATS_EN
        .stats_clr_i(stats_clr), .gated_cnt_o(gated_cnt_on),
`endif
        .clk_o(clk_g_on), .clk_en_o(clk_en_on), .ready_o(ready_on), .all_gated_o(all_gated_on),
        .state_dbg_o(state_dbg_on)
    );

    // Advance n active edges and settle just after the last one.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        checks++; if (clk_en !== 4'b0000) begin errors++; $display("FAIL reset_clk_en got %b exp 0000", clk_en); end
        checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", ready); end
        checks++; if (all_gated !== 1'b1) begin errors++; $display("FAIL reset_all_gated got %b exp 1", all_gated); end
        checks++; if (clk_g !== 4'b0000) begin errors++; $display("FAIL reset_clk_o got %b exp 0000", clk_g); end
        checks++; if (clk_en_on !== 4'b1111) begin errors++; $display("FAIL reset_on_clk_en got %b exp 1111", clk_en_on); end
        checks++; if (ready_on !== 4'b1111) begin errors++; $display("FAIL reset_on_ready got %b exp 1111", ready_on); end
        checks++; if (all_gated_on !== 1'b0) begin errors++; $display("FAIL reset_on_all_gated got %b exp 0", all_gated_on); end
        checks++; if (clk_g_on !== 4'b1111) begin errors++; $display("FAIL reset_on_clk_o got %b exp 1111", clk_g_on); end
        rst = 1'b0;
        tick(1);
    endtask

    // Single-cycle req pulse on ch0; WAKE completes without req held.
    task automatic test_wake();
        req = 4'b0001;
        tick(1);
        req = 4'b0000;
        checks++; if (clk_en[0] !== 1'b1) begin errors++; $display("FAIL wake_en_t1 got %b exp 1", clk_en[0]); end
        checks++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL wake_ready_t1 got %b exp 0", ready[0]); end
        checks++; if (clk_g[0] !== 1'b0) begin errors++; $display("FAIL wake_clk_o_t1 got %b exp 0", clk_g[0]); end
        tick(1);
        checks++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL wake_ready_t2 got %b exp 0", ready[0]); end
        checks++; if (clk_g[0] !== 1'b1) begin errors++; $display("FAIL wake_clk_o_t2 got %b exp 1", clk_g[0]); end
        checks++; if (all_gated !== 1'b0) begin errors++; $display("FAIL wake_all_gated got %b exp 0", all_gated); end
        tick(1);
        checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL wake_ready_t3 got %b exp 1", ready[0]); end
        checks++; if (state_dbg[0] !== ON) begin errors++; $display("FAIL wake_state got %0d exp %0d", state_dbg[0], ON); end
    endtask

    // Threshold 5: count reaches 5 after five idle edges, gate closes on the sixth.
    task automatic test_idle_gate();
        tick(5);
        checks++; if (clk_en[0] !== 1'b1) begin errors++; $display("FAIL idle_en_before got %b exp 1", clk_en[0]); end
        checks++; if (dut.g_ch[0].u_chan.idle_q !== 8'd5) begin errors++; $display("FAIL idle_cnt5 got %0d exp 5", dut.g_ch[0].u_chan.idle_q); end
        tick(1);
        checks++; if (clk_en[0] !== 1'b0) begin errors++; $display("FAIL idle_en_after got %b exp 0", clk_en[0]); end
        checks++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL idle_ready_after got %b exp 0", ready[0]); end
        checks++; if (all_gated !== 1'b1) begin errors++; $display("FAIL idle_all_gated got %b exp 1", all_gated); end
    endtask

    task automatic test_activity_wins();
        req = 4'b0001;
        tick(1);
        req = 4'b0000;
        tick(2);
        tick(5);
        req = 4'b0001;
        tick(1);
        req = 4'b0000;
        checks++; if (clk_en[0] !== 1'b1) begin errors++; $display("FAIL act_win_en got %b exp 1", clk_en[0]); end
        checks++; if (dut.g_ch[0].u_chan.idle_q !== 8'd0) begin errors++; $display("FAIL act_win_cnt got %0d exp 0", dut.g_ch[0].u_chan.idle_q); end
        tick(6);
        checks++; if (clk_en[0] !== 1'b0) begin errors++; $display("FAIL act_win_regate got %b exp 0", clk_en[0]); end
    endtask

    // Threshold 0 disables gating; lowering it under the saturated count gates next edge.
    task automatic test_saturate();
        idle_thr[0] = 8'd0;
        req = 4'b0001;
        tick(1);
        req = 4'b0000;
        tick(2);
        tick(300);
        checks++; if (clk_en[0] !== 1'b1) begin errors++; $display("FAIL sat_en got %b exp 1", clk_en[0]); end
        checks++; if (dut.g_ch[0].u_chan.idle_q !== 8'd255) begin errors++; $display("FAIL sat_cnt got %0d exp 255", dut.g_ch[0].u_chan.idle_q); end
        idle_thr[0] = 8'd200;
        tick(1);
        checks++; if (clk_en[0] !== 1'b0) begin errors++; $display("FAIL thr_lowered got %b exp 0", clk_en[0]); end
    endtask

    task automatic test_busy_force();
        busy = 4'b0010;
        tick(5);
        busy = 4'b0000;
        checks++; if (clk_en[1] !== 1'b0) begin errors++; $display("FAIL busy_no_wake got %b exp 0", clk_en[1]); end
        checks++; if (state_dbg[1] !== OFF) begin errors++; $display("FAIL busy_state got %0d exp %0d", state_dbg[1], OFF); end
        idle_thr[3] = 8'd1;
        force_on = 4'b1000;
        tick(3);
        checks++; if (ready[3] !== 1'b1) begin errors++; $display("FAIL force_ready got %b exp 1", ready[3]); end
        tick(5);
        checks++; if (clk_en[3] !== 1'b1) begin errors++; $display("FAIL force_hold got %b exp 1", clk_en[3]); end
        force_on = 4'b0000;
        tick(1);
        checks++; if (clk_en[3] !== 1'b1) begin errors++; $display("FAIL force_rel_t1 got %b exp 1", clk_en[3]); end
        tick(1);
        checks++; if (clk_en[3] !== 1'b0) begin errors++; $display("FAIL force_rel_t2 got %b exp 0", clk_en[3]); end
    endtask

    task automatic test_test_en();
        test_en = 1'b1;
        tick(1);
        checks++; if (clk_g !== 4'b1111) begin errors++; $display("FAIL testen_high got %b exp 1111", clk_g); end
        @(negedge clk);
        #1;
        checks++; if (clk_g !== 4'b0000) begin errors++; $display("FAIL testen_low got %b exp 0000", clk_g); end
        checks++; if (clk_en !== 4'b0000) begin errors++; $display("FAIL testen_status got %b exp 0000", clk_en); end
        test_en = 1'b0;
        tick(2);
        checks++; if (clk_g !== 4'b0000) begin errors++; $display("FAIL testen_off got %b exp 0000", clk_g); end
    endtask

    task automatic test_rst_mid_wake();
        req = 4'b0100;
        tick(1);
        req = 4'b0000;
        checks++; if (state_dbg[2] !== WAKE) begin errors++; $display("FAIL rst_wake_state got %0d exp %0d", state_dbg[2], WAKE); end
        rst = 1'b1;
        tick(1);
        checks++; if (clk_en[2] !== 1'b0) begin errors++; $display("FAIL rst_mid_wake_en got %b exp 0", clk_en[2]); end
        checks++; if (state_dbg[2] !== OFF) begin errors++; $display("FAIL rst_mid_wake_state got %0d exp %0d", state_dbg[2], OFF); end
        rst = 1'b0;
        tick(1);
    endtask

`ifdef CLK_GATE_CTRL_STATS_EN
    task automatic test_stats();
        stats_clr = 1'b1;
        tick(1);
        stats_clr = 1'b0;
        tick(20);
        checks++; if (gated_cnt[1] !== 32'd20) begin errors++; $display("FAIL stats_cnt got %0d exp 20", gated_cnt[1]); end
        stats_clr = 1'b1;
        tick(1);
        stats_clr = 1'b0;
        checks++; if (gated_cnt[1] !== 32'd0) begin errors++; $display("FAIL stats_clr got %0d exp 0", gated_cnt[1]); end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        test_en  = 1'b0;
        req      = '0;
        busy     = '0;
        force_on = '0;
        idle_thr = '0;
        idle_thr[0] = 8'd5;
`ifdef CLK_GATE_CTRL_STATS_EN
        stats_clr = 1'b0;
`endif
        test_reset();
        test_wake();
        test_idle_gate();
        test_activity_wins();
        test_saturate();
        test_busy_force();
        test_test_en();
        test_rst_mid_wake();
`ifdef CLK_GATE_CTRL_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
